// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline sequencer: the FSM state encoding
// and the register-index width.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned RegIdxW = 4;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StStall   = 2'd1,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CntW = 16
);
  import pipeline_hazard_ctrl_pkg::*;

  logic               id_valid;
  logic [RegIdxW-1:0] id_src1;
  logic [RegIdxW-1:0] id_src2;
  logic               id_two_src;
  logic [RegIdxW-1:0] exe_dest;
  logic               exe_wb_en;
  logic               exe_mem_read;
  logic [RegIdxW-1:0] mem_dest;
  logic               mem_wb_en;
  logic               branch_taken;
  logic               mem_req;
  logic               mem_ready;

  logic               hazard;
  logic               freeze_pc;
  logic               freeze_id_exe;
  logic               freeze_exe_mem;
  logic               flush_if_id;
  logic               flush_id_exe;
  pipe_state_t        state;
  logic [CntW-1:0]    stall_cycles;
  logic [CntW-1:0]    flush_count;
  logic               mem_timeout;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  hazard, freeze_pc, freeze_id_exe, freeze_exe_mem, flush_if_id, flush_id_exe,
           state, stall_cycles, flush_count, mem_timeout
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output hazard, freeze_pc, freeze_id_exe, freeze_exe_mem, flush_if_id, flush_id_exe,
           state, stall_cycles, flush_count, mem_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW compare of the ID source indices against the EXE and MEM
// destinations; with forwarding only a load in EXE can cause a stall.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit ForwardEn = 1'b0
) (
  input  logic [RegIdxW-1:0] id_src1_i,
  input  logic [RegIdxW-1:0] id_src2_i,
  input  logic               id_two_src_i,
  input  logic [RegIdxW-1:0] exe_dest_i,
  input  logic               exe_wb_en_i,
  input  logic               exe_mem_read_i,
  input  logic [RegIdxW-1:0] mem_dest_i,
  input  logic               mem_wb_en_i,
  output logic               raw1_o,
  output logic               raw2_o
);

  logic exe_hit_en;
  logic mem_hit_en;

  always_comb begin
    exe_hit_en = exe_wb_en_i & (ForwardEn ? exe_mem_read_i : 1'b1);
    // Forwarding covers every MEM-stage producer.
    mem_hit_en = mem_wb_en_i & ~ForwardEn;
    raw1_o     = (exe_hit_en & (id_src1_i == exe_dest_i)) |
                 (mem_hit_en & (id_src1_i == mem_dest_i));
    raw2_o     = id_two_src_i &
                 ((exe_hit_en & (id_src2_i == exe_dest_i)) |
                  (mem_hit_en & (id_src2_i == mem_dest_i)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush control for a 5-stage pipe with priority
// memory-wait > taken-branch > RAW stall, plus saturating statistics and a memory watchdog.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit          ForwardEn  = 1'b0,
  parameter int unsigned CntW       = 16,
  parameter int unsigned MemTimeout = 255
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned TmoW  = $clog2(MemTimeout + 1);
  localparam int unsigned WaitW = (TmoW > 8) ? TmoW : 8;

  logic raw1;
  logic raw2;
  logic mem_busy;
  logic flush_apply;
  logic hazard;

  pipe_state_t     state_d;
  pipe_state_t     state_q;
  logic [CntW-1:0] stall_cycles_q;
  logic [CntW-1:0] flush_count_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic            mem_timeout_q;

  pipeline_hazard_ctrl_hazard_detect #(
    .ForwardEn(ForwardEn)
  ) u_hazard_detect (
    .id_src1_i     (bus.id_src1),
    .id_src2_i     (bus.id_src2),
    .id_two_src_i  (bus.id_two_src),
    .exe_dest_i    (bus.exe_dest),
    .exe_wb_en_i   (bus.exe_wb_en),
    .exe_mem_read_i(bus.exe_mem_read),
    .mem_dest_i    (bus.mem_dest),
    .mem_wb_en_i   (bus.mem_wb_en),
    .raw1_o        (raw1),
    .raw2_o        (raw2)
  );

  always_comb begin
    mem_busy    = bus.mem_req & ~bus.mem_ready;
    // A branch seen while memory is busy stays in EXE and is flushed on release.
    flush_apply = bus.branch_taken & ~mem_busy;
    hazard      = bus.id_valid & (raw1 | raw2) & ~bus.branch_taken & ~mem_busy;

    state_d = StRun;
    if (mem_busy) begin
      state_d = StMemWait;
    end else if (flush_apply) begin
      state_d = StFlush;
    end else if (hazard) begin
      state_d = StStall;
    end
  end

  always_comb begin
    bus.hazard         = hazard;
    bus.freeze_pc      = mem_busy | hazard;
    bus.freeze_id_exe  = mem_busy;
    bus.freeze_exe_mem = mem_busy;
    bus.flush_if_id    = flush_apply;
    bus.flush_id_exe   = flush_apply | hazard;
    bus.state          = state_q;
    bus.stall_cycles   = stall_cycles_q;
    bus.flush_count    = flush_count_q;
    bus.mem_timeout    = mem_timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((hazard | mem_busy) && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CntW'(1);
      end
      if (flush_apply && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + CntW'(1);
      end

      // Watchdog only reports; the freeze is never broken by it.
      if (mem_busy) begin
        if (wait_cnt_q != '1) begin
          wait_cnt_q <= wait_cnt_q + WaitW'(1);
        end
        if (wait_cnt_q == WaitW'(MemTimeout)) begin
          mem_timeout_q <= 1'b1;
        end
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: dut_a (no forwarding, short watchdog) and dut_b (forwarding, 2-bit counters)
// see the same directed vectors; expected responses are queued and checked on the falling edge.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CntW(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.CntW(2))  bus_b ();

  pipeline_hazard_ctrl #(.ForwardEn(1'b0), .CntW(16), .MemTimeout(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  pipeline_hazard_ctrl #(.ForwardEn(1'b1), .CntW(2), .MemTimeout(255)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  logic       id_valid, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

  assign {bus_a.id_valid, bus_a.id_src1, bus_a.id_src2, bus_a.id_two_src, bus_a.exe_dest,
          bus_a.exe_wb_en, bus_a.exe_mem_read, bus_a.mem_dest, bus_a.mem_wb_en,
          bus_a.branch_taken, bus_a.mem_req, bus_a.mem_ready} =
         {id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
          mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready};
  assign {bus_b.id_valid, bus_b.id_src1, bus_b.id_src2, bus_b.id_two_src, bus_b.exe_dest,
          bus_b.exe_wb_en, bus_b.exe_mem_read, bus_b.mem_dest, bus_b.mem_wb_en,
          bus_b.branch_taken, bus_b.mem_req, bus_b.mem_ready} =
         {id_valid, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
          mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready};

  // ctl = {hazard, freeze_pc, freeze_id_exe, freeze_exe_mem, flush_if_id, flush_id_exe}
  typedef struct {
    int          dut;
    string       name;
    logic [5:0]  ctl;
    pipe_state_t st;
    int          stall;
    int          flush;
    logic        tmo;
  } exp_t;

  localparam logic [5:0] CtlIdle  = 6'b000000;
  localparam logic [5:0] CtlHaz   = 6'b110001;
  localparam logic [5:0] CtlFlush = 6'b000011;
  localparam logic [5:0] CtlMem   = 6'b011100;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic set_in(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] ed, input logic ewb,
                        input logic emr, input logic [3:0] md, input logic mwb,
                        input logic br, input logic mreq, input logic mrdy);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    exe_dest = ed; exe_wb_en = ewb; exe_mem_read = emr;
    mem_dest = md; mem_wb_en = mwb; branch_taken = br; mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic idle();
    set_in(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic expect_a(input string name, input logic [5:0] ctl, input pipe_state_t st,
                          input int stall, input int flush, input logic tmo);
    exp_t e;
    e.dut = 0; e.name = name; e.ctl = ctl; e.st = st;
    e.stall = stall; e.flush = flush; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic expect_b(input string name, input logic [5:0] ctl, input pipe_state_t st,
                          input int stall, input int flush, input logic tmo);
    exp_t e;
    e.dut = 1; e.name = name; e.ctl = ctl; e.st = st;
    e.stall = stall; e.flush = flush; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation against the live outputs mid-cycle.
  initial begin
    exp_t       e;
    logic [5:0] ctl;
    logic [1:0] st;
    int         stall, flush;
    logic       tmo;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          ctl   = {bus_a.hazard, bus_a.freeze_pc, bus_a.freeze_id_exe, bus_a.freeze_exe_mem,
                   bus_a.flush_if_id, bus_a.flush_id_exe};
          st    = bus_a.state;
          stall = int'(bus_a.stall_cycles);
          flush = int'(bus_a.flush_count);
          tmo   = bus_a.mem_timeout;
        end else begin
          ctl   = {bus_b.hazard, bus_b.freeze_pc, bus_b.freeze_id_exe, bus_b.freeze_exe_mem,
                   bus_b.flush_if_id, bus_b.flush_id_exe};
          st    = bus_b.state;
          stall = int'(bus_b.stall_cycles);
          flush = int'(bus_b.flush_count);
          tmo   = bus_b.mem_timeout;
        end
        n_tests++;
        if (ctl !== e.ctl || st !== e.st || stall != e.stall || flush != e.flush ||
            tmo !== e.tmo) begin
          n_fail++;
          $display("FAIL %s dut%0d: got ctl=%b st=%0d stall=%0d flush=%0d tmo=%b, want ctl=%b st=%0d stall=%0d flush=%0d tmo=%b",
                   e.name, e.dut, ctl, st, stall, flush, tmo,
                   e.ctl, e.st, e.stall, e.flush, e.tmo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    expect_a("reset", CtlIdle, StRun, 0, 0, 0);
    expect_b("reset", CtlIdle, StRun, 0, 0, 0);
    tick();

    // EXE ALU producer of r1, ID reads r1.
    set_in(1, 4'd1, 4'd0, 0, 4'd1, 1, 0, 4'd0, 0, 0, 0, 0);
    expect_a("raw_exe_alu", CtlHaz, StRun, 0, 0, 0);
    expect_b("fwd_alu_no_stall", CtlIdle, StRun, 0, 0, 0);
    tick();

    // Same, but the EXE producer is a load.
    set_in(1, 4'd1, 4'd0, 0, 4'd1, 1, 1, 4'd0, 0, 0, 0, 0);
    expect_a("raw_exe_load", CtlHaz, StStall, 1, 0, 0);
    expect_b("load_use", CtlHaz, StRun, 0, 0, 0);
    tick();

    idle();
    expect_a("after_stall", CtlIdle, StStall, 2, 0, 0);
    expect_b("after_load_use", CtlIdle, StStall, 1, 0, 0);
    tick();

    // MEM producer of r5 read through src2.
    set_in(1, 4'd3, 4'd5, 1, 4'd0, 0, 0, 4'd5, 1, 0, 0, 0);
    expect_a("raw_mem_src2", CtlHaz, StRun, 2, 0, 0);
    expect_b("fwd_mem_no_stall", CtlIdle, StRun, 1, 0, 0);
    tick();

    // src2 not actually read.
    set_in(1, 4'd3, 4'd5, 0, 4'd0, 0, 0, 4'd5, 1, 0, 0, 0);
    expect_a("src2_unused", CtlIdle, StStall, 3, 0, 0);
    expect_b("src2_unused", CtlIdle, StRun, 1, 0, 0);
    tick();

    // Taken branch overrides a RAW on r2.
    set_in(1, 4'd2, 4'd0, 0, 4'd2, 1, 1, 4'd0, 0, 1, 0, 0);
    expect_a("branch_over_raw", CtlFlush, StRun, 3, 0, 0);
    expect_b("branch_over_raw", CtlFlush, StRun, 1, 0, 0);
    tick();

    idle();
    expect_a("after_flush", CtlIdle, StFlush, 3, 1, 0);
    expect_b("after_flush", CtlIdle, StFlush, 1, 1, 0);
    tick();

    // Branch deferred behind three memory-busy cycles.
    set_in(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 1, 0);
    expect_a("memwait_br_1", CtlMem, StRun, 3, 1, 0);
    expect_b("memwait_br_1", CtlMem, StRun, 1, 1, 0);
    tick();
    expect_a("memwait_br_2", CtlMem, StMemWait, 4, 1, 0);
    expect_b("memwait_br_2", CtlMem, StMemWait, 2, 1, 0);
    tick();
    expect_a("memwait_br_3", CtlMem, StMemWait, 5, 1, 0);
    expect_b("memwait_br_3", CtlMem, StMemWait, 3, 1, 0);
    tick();

    set_in(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 1, 1);
    expect_a("mem_release_flush", CtlFlush, StMemWait, 6, 1, 0);
    expect_b("mem_release_flush", CtlFlush, StMemWait, 3, 1, 0);
    tick();

    // Back-to-back branches push dut_b's 2-bit flush_count into saturation.
    set_in(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, 0);
    expect_a("branch_2", CtlFlush, StFlush, 6, 2, 0);
    expect_b("branch_2", CtlFlush, StFlush, 3, 2, 0);
    tick();
    expect_a("branch_3", CtlFlush, StFlush, 6, 3, 0);
    expect_b("branch_3", CtlFlush, StFlush, 3, 3, 0);
    tick();
    expect_a("branch_4", CtlFlush, StFlush, 6, 4, 0);
    expect_b("flush_sat", CtlFlush, StFlush, 3, 3, 0);
    tick();

    idle();
    expect_a("after_branches", CtlIdle, StFlush, 6, 5, 0);
    expect_b("after_branches", CtlIdle, StFlush, 3, 3, 0);
    tick();

    // Six busy cycles: dut_a's watchdog (limit 4) trips after the fifth.
    set_in(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      expect_a($sformatf("wdog_busy_%0d", k), CtlMem, (k == 1) ? StRun : StMemWait,
               5 + k, 5, (k == 6));
      expect_b($sformatf("wdog_busy_%0d", k), CtlMem, (k == 1) ? StRun : StMemWait,
               3, 3, 0);
      tick();
    end

    idle();
    expect_a("tmo_sticky_1", CtlIdle, StMemWait, 12, 5, 1);
    expect_b("no_tmo", CtlIdle, StMemWait, 3, 3, 0);
    tick();
    expect_a("tmo_sticky_2", CtlIdle, StRun, 12, 5, 1);
    expect_b("idle_run", CtlIdle, StRun, 3, 3, 0);
    tick();

    // Reset asserted during a memory wait with busy inputs still applied.
    set_in(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 1, 0);
    expect_a("enter_wait", CtlMem, StRun, 12, 5, 1);
    expect_b("enter_wait", CtlMem, StRun, 3, 3, 0);
    tick();
    rst = 1'b1;
    expect_a("rst_in_wait", CtlMem, StMemWait, 13, 5, 1);
    expect_b("rst_in_wait", CtlMem, StMemWait, 3, 3, 0);
    tick();
    rst = 1'b0;
    idle();
    expect_a("post_rst", CtlIdle, StRun, 0, 0, 0);
    expect_b("post_rst", CtlIdle, StRun, 0, 0, 0);
    tick();

    // R15 is an ordinary index.
    set_in(1, 4'd15, 4'd0, 0, 4'd15, 1, 0, 4'd0, 0, 0, 0, 0);
    expect_a("raw_r15", CtlHaz, StRun, 0, 0, 0);
    expect_b("fwd_r15", CtlIdle, StRun, 0, 0, 0);
    tick();

    idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
